// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

   localparam int unsigned LEN_W          = 16;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
   localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid pulses for
// one cycle after the fourth byte of each word is strobed in.
module word_packer
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        data,
   input  logic              strobe,
   input  logic              clear,
   output logic [WORD_W-1:0] word,
   output logic              word_valid,
   output logic              last_lane_c
);

   logic [LANE_W-1:0] lane;
   logic [23:0]       acc;

   // The byte being strobed now completes a word.
   assign last_lane_c = (lane == LANE_W'(BYTES_PER_WORD - 1));

   // Lane counter, byte accumulator and registered word output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane       <= '0;
         acc        <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            lane <= '0;
         end else if (strobe) begin
            lane <= lane + LANE_W'(1);
            case (lane)
               2'd0:    acc[7:0]   <= data;
               2'd1:    acc[15:8]  <= data;
               2'd2:    acc[23:16] <= data;
               default: begin
                  word       <= {data, acc};
                  word_valid <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed byte image and writes it into
// the instruction memory, holding the core until the last word is written.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [WORD_W-1:0] wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t           state;
   logic [7:0]       len_lo;
   logic [LEN_W-1:0] n_words;
   logic [LEN_W-1:0] word_cnt;
   logic             fin_wait;

   logic             xfer;
   logic             pk_strobe;
   logic             pk_clear;
   logic             pk_last_c;
   logic [LEN_W-1:0] len_c;

   assign xfer      = rx_valid && rx_ready;
   assign pk_strobe = xfer && (state == ST_DATA);
   assign pk_clear  = start && (state == ST_IDLE);
   assign len_c     = {rx_data, len_lo};

   // The packer's registered word and strobe drive the memory port directly.
   word_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .data        (rx_data),
      .strobe      (pk_strobe),
      .clear       (pk_clear),
      .word        (wdata),
      .word_valid  (we),
      .last_lane_c (pk_last_c)
   );

   // Load sequencer with word counter and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         len_lo   <= '0;
         n_words  <= '0;
         word_cnt <= '0;
         fin_wait <= 1'b0;
         rx_ready <= 1'b0;
         waddr    <= '0;
         cpu_hold <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_LEN_LO;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_hold <= 1'b1;
                  word_cnt <= '0;
                  rx_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_LEN_LO: begin
               if (xfer) begin
                  len_lo <= rx_data;
                  state  <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (xfer) begin
                  n_words <= len_c;
                  if (len_c == '0) begin
                     state    <= ST_FINISH;
                     rx_ready <= 1'b0;
                  end else if (32'(len_c) > DEPTH) begin
                     // Oversized image: abort with the core still held.
                     state    <= ST_IDLE;
                     err      <= 1'b1;
                     rx_ready <= 1'b0;
                     busy     <= 1'b0;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (xfer && pk_last_c) begin
                  waddr    <= word_cnt[ADDR_W-1:0];
                  word_cnt <= word_cnt + LEN_W'(1);
                  if (word_cnt == n_words - LEN_W'(1)) begin
                     state    <= ST_FINISH;
                     rx_ready <= 1'b0;
                  end
               end
            end
            ST_FINISH: begin
               // Two cycles here so the final write lands before the core runs.
               if (!fin_wait) begin
                  fin_wait <= 1'b1;
               end else begin
                  fin_wait <= 1'b0;
                  state    <= ST_IDLE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               rx_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized image loads compared against
// an expected write list computed straight from the stream format.
module tb_imem_loader;

   localparam int unsigned DEPTH  = 256;
   localparam int unsigned ADDR_W = 8;

   typedef logic [7:0] byte_q_t[$];

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   int n_vec = 0;
   int n_err = 0;

   logic [ADDR_W-1:0] cap_addr[$];
   logic [31:0]       cap_data[$];

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Record every memory write, sampled mid-cycle.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         cap_addr.push_back(waddr);
         cap_data.push_back(wdata);
      end
   end

   // Expected word i of an image: byte 4i in bits 7:0, byte 4i+3 in bits 31:24.
   function automatic logic [31:0] word_of(input byte_q_t d, input int i);
      return 32'(d[4*i]) + (32'(d[4*i+1]) << 8) + (32'(d[4*i+2]) << 16) + (32'(d[4*i+3]) << 24);
   endfunction

   // Stream bytes; mode 0 back-to-back, 1 valid every other cycle, 2 random gaps.
   // Returns just after the edge that transferred the last byte.
   task automatic send_bytes(input byte_q_t bytes, input int mode, input string name);
      int  idx = 0;
      int  cyc = 0;
      logic xf;
      while (idx < bytes.size() && cyc < 20000) begin
         case (mode)
            0:       rx_valid = 1'b1;
            1:       rx_valid = (cyc % 2 == 0);
            default: rx_valid = 1'($urandom_range(0, 1));
         endcase
         rx_data = rx_valid ? bytes[idx] : 8'($urandom);
         xf = rx_valid && rx_ready;
         @(posedge clk); #1;
         if (xf) idx++;
         cyc++;
      end
      rx_valid = 1'b0;
      if (idx < bytes.size()) begin
         n_vec++; n_err++;
         $display("FAIL %s send timeout: sent %0d of %0d bytes", name, idx, bytes.size());
      end
   endtask

   task automatic do_start(input string name);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_vec++;
      if ({rx_ready, busy, done, err, cpu_hold} !== 5'b11001) begin
         n_err++;
         $display("FAIL %s start: {ready,busy,done,err,hold}=%b want 11001", name,
                  {rx_ready, busy, done, err, cpu_hold});
      end
   endtask

   // Full load of an image with timing and write-list checks.
   task automatic run_load(input byte_q_t data, input int mode, input string name);
      int      n = data.size() / 4;
      byte_q_t s;
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      foreach (data[i]) s.push_back(data[i]);
      cap_addr.delete();
      cap_data.delete();
      do_start(name);
      send_bytes(s, mode, name);
      // Cycle right after the last transfer.
      n_vec++;
      if (n > 0) begin
         if (we !== 1'b1 || waddr !== ADDR_W'(n - 1) || wdata !== word_of(data, n - 1) ||
             rx_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            n_err++;
            $display("FAIL %s last write: we=%b addr=%0d data=%h ready=%b done=%b hold=%b want 1 %0d %h 0 0 1",
                     name, we, waddr, wdata, rx_ready, done, cpu_hold, n - 1, word_of(data, n - 1));
         end
      end else if (we !== 1'b0 || rx_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
         n_err++;
         $display("FAIL %s after len: we=%b ready=%b done=%b hold=%b want 0 0 0 1",
                  name, we, rx_ready, done, cpu_hold);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({we, done, cpu_hold, busy, rx_ready} !== 5'b00110) begin
         n_err++;
         $display("FAIL %s finish cycle: {we,done,hold,busy,ready}=%b want 00110", name,
                  {we, done, cpu_hold, busy, rx_ready});
      end
      @(posedge clk); #1;
      n_vec++;
      if ({done, cpu_hold, busy, err} !== 4'b1000) begin
         n_err++;
         $display("FAIL %s complete: {done,hold,busy,err}=%b want 1000", name,
                  {done, cpu_hold, busy, err});
      end
      n_vec++;
      if (cap_addr.size() != n) begin
         n_err++;
         $display("FAIL %s write count: got %0d want %0d", name, cap_addr.size(), n);
      end
      for (int i = 0; i < n && i < cap_addr.size(); i++) begin
         n_vec++;
         if (cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== word_of(data, i)) begin
            n_err++;
            $display("FAIL %s write %0d: got (%0d,%h) want (%0d,%h)", name, i,
                     cap_addr[i], cap_data[i], i, word_of(data, i));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({rx_ready, we, waddr, wdata, cpu_hold, busy, done, err} !==
          {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset values: ready=%b we=%b addr=%0d data=%h hold=%b busy=%b done=%b err=%b",
                  rx_ready, we, waddr, wdata, cpu_hold, busy, done, err);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (rx_ready !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle ready: ready=%b busy=%b want 0 0", rx_ready, busy);
      end
   endtask

   task automatic test_basic(input int mode, input string name);
      byte_q_t d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load(d, mode, name);
   endtask

   task automatic test_zero();
      byte_q_t d;
      run_load(d, 0, "zero_len");
   endtask

   task automatic test_too_long();
      byte_q_t s = '{8'h01, 8'h01};
      logic    ready_seen = 1'b0;
      cap_addr.delete();
      cap_data.delete();
      do_start("too_long");
      send_bytes(s, 0, "too_long");
      n_vec++;
      if ({err, busy, cpu_hold, rx_ready, done} !== 5'b10100) begin
         n_err++;
         $display("FAIL too_long flags: {err,busy,hold,ready,done}=%b want 10100",
                  {err, busy, cpu_hold, rx_ready, done});
      end
      rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'($urandom);
         if (rx_ready !== 1'b0) ready_seen = 1'b1;
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      n_vec++;
      if (ready_seen !== 1'b0 || cap_addr.size() != 0 || err !== 1'b1) begin
         n_err++;
         $display("FAIL too_long after: ready_seen=%b writes=%0d err=%b want 0 0 1",
                  ready_seen, cap_addr.size(), err);
      end
   endtask

   task automatic test_full();
      byte_q_t d;
      for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom));
      run_load(d, 2, "full_image");
      n_vec++;
      if (cap_addr.size() == 0 || cap_addr[cap_addr.size() - 1] !== ADDR_W'(DEPTH - 1)) begin
         n_err++;
         $display("FAIL full_image last addr: got %0d want %0d",
                  (cap_addr.size() == 0) ? -1 : int'(cap_addr[cap_addr.size() - 1]), DEPTH - 1);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++) begin
         byte_q_t d;
         int      n = int'($urandom_range(1, 6));
         for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
         run_load(d, 2, $sformatf("random_%0d", t));
      end
   endtask

   task automatic test_rst_mid_load();
      byte_q_t hdr  = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      byte_q_t tail = '{8'h44, 8'h55};
      byte_q_t beef = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      cap_addr.delete();
      cap_data.delete();
      do_start("mid_load");
      send_bytes(hdr, 0, "mid_load");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_load start ignored: busy=%b ready=%b want 1 1", busy, rx_ready);
      end
      send_bytes(tail, 0, "mid_load");
      n_vec++;
      if (cap_addr.size() != 1 || cap_data[0] !== 32'h44332211 || cap_addr[0] !== '0) begin
         n_err++;
         $display("FAIL mid_load partial: writes=%0d first=%h want 1 44332211", cap_addr.size(),
                  (cap_data.size() != 0) ? cap_data[0] : 32'h0);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({rx_ready, we, waddr, wdata, cpu_hold, busy, done, err} !==
          {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mid_load reset: ready=%b we=%b addr=%0d data=%h hold=%b busy=%b done=%b err=%b",
                  rx_ready, we, waddr, wdata, cpu_hold, busy, done, err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_load(beef, 0, "deadbeef");
   endtask

   initial begin
      test_reset();
      test_basic(0, "back_to_back");
      test_basic(1, "alternate_valid");
      test_zero();
      test_too_long();
      test_full();
      test_random();
      test_rst_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
